// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction cache geometry, address fields and FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned IIDX_W  = 4;
    localparam int unsigned ITAG_W  = 26;
    localparam int unsigned IBOFF_W = 2;
    localparam int unsigned IFRAMES = 1 << IIDX_W;

    // Instruction address split into cache fields
    typedef struct packed {
        logic [ITAG_W-1:0]  tag;
        logic [IIDX_W-1:0]  idx;
        logic [IBOFF_W-1:0] bytoff;
    } icachef_t;

    // Instruction cache controller states
    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage : cpu_types_pkg

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking
// miss FSM. Hits are returned combinationally in the request cycle.
module icache
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    // datapath side
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    input  logic              flush,
    // memory controller side
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    // statistics
    output logic [WORD_W-1:0] hit_count,
    output logic [WORD_W-1:0] miss_count
);

    icache_state_t state, next_state;

    logic [IFRAMES-1:0] valid;
    logic [ITAG_W-1:0]  tags [IFRAMES];
    logic [WORD_W-1:0]  data [IFRAMES];

    logic [WORD_W-1:0]  miss_addr;
    icachef_t           req;
    icachef_t           miss;

    logic               tag_match;
    logic               start_fetch;
    logic               fill_done;
    logic               unused_bits;

    assign req  = icachef_t'(imemaddr);
    assign miss = icachef_t'(miss_addr);

    // Byte offsets never select anything in a word-per-frame cache
    assign unused_bits = ^{req.bytoff, miss.bytoff};

    assign tag_match = valid[req.idx] && (tags[req.idx] == req.tag);

    // FSM state register; reset overrides every transition
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, hit path and memory request decode
    always_comb begin
        next_state  = state;
        ihit        = 1'b0;
        imemload    = '0;
        iREN        = 1'b0;
        iaddr       = miss_addr;
        start_fetch = 1'b0;
        fill_done   = 1'b0;
        unique case (state)
            IDLE: begin
                ihit = imemREN && tag_match;
                if (ihit) begin
                    imemload = data[req.idx];
                end
                // A flush cycle must not launch a fill of stale contents
                if (imemREN && !tag_match && !flush) begin
                    start_fetch = 1'b1;
                    next_state  = FETCH;
                end
            end
            FETCH: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Miss address latch, word aligned
    always_ff @(posedge CLK) begin
        if (RST) begin
            miss_addr <= '0;
        end else if (start_fetch) begin
            miss_addr <= {imemaddr[WORD_W-1:IBOFF_W], IBOFF_W'(0)};
        end
    end

    // Valid bits: flush beats a completing fill
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[miss.idx] <= 1'b1;
        end
    end

    // Tag and data arrays, written only by a completing fill
    always_ff @(posedge CLK) begin
        if (!RST && fill_done) begin
            tags[miss.idx] <= miss.tag;
            data[miss.idx] <= iload;
        end
    end

    // Hit and miss statistics, wrapping naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) begin
                hit_count <= hit_count + WORD_W'(1);
            end
            if (start_fetch) begin
                miss_count <= miss_count + WORD_W'(1);
            end
        end
    end

endmodule : icache

// File: tb/tb_icache.sv
// Directed self-checking bench for the instruction cache.
module tb_icache;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hit  = 32'd0;
    logic [31:0] exp_miss = 32'd0;

    icache dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    // Time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hits"},   hit_count,  exp_hit);
        check({tag, "_misses"}, miss_count, exp_miss);
    endtask

    // Miss on addr, hold iwait for waits FETCH cycles, deliver word, then expect a hit
    task automatic fill(input logic [31:0] addr, input int waits, input logic [31:0] word);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        #1;
        check("miss_ihit", {31'd0, ihit}, 32'd0);
        check("miss_load", imemload, 32'd0);
        @(negedge CLK);
        exp_miss++;
        for (int i = 0; i < waits; i++) begin
            check("wait_iren",  {31'd0, iREN}, 32'd1);
            check("wait_iaddr", iaddr, {addr[31:2], 2'b00});
            check("wait_ihit",  {31'd0, ihit}, 32'd0);
            @(negedge CLK);
        end
        iwait = 1'b0;
        iload = word;
        #1;
        check("done_iren",  {31'd0, iREN}, 32'd1);
        check("done_iaddr", iaddr, {addr[31:2], 2'b00});
        @(negedge CLK);
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
        #1;
        check("after_iren", {31'd0, iREN}, 32'd0);
        check("after_ihit", {31'd0, ihit}, 32'd1);
        check("after_load", imemload, word);
        @(negedge CLK);
        exp_hit++;
        imemREN = 1'b0;
    endtask

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = 32'd0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_ihit",  {31'd0, ihit}, 32'd0);
        check("rst_load",  imemload, 32'd0);
        check("rst_iren",  {31'd0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check_counts("rst");
        @(negedge CLK);

        // first fill with three wait cycles
        fill(32'h0000_0000, 3, 32'h8C01_0004);
        check_counts("first_fill");

        // conflicting tag on index 0 evicts, and the old line misses again
        fill(32'h0000_0040, 0, 32'h1111_1111);
        fill(32'h0000_0000, 0, 32'h8C01_0004);
        check("evict_misses", miss_count, 32'd3);
        check_counts("evict");

        // unaligned address hits the same word
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0003;
        #1;
        check("unaligned_ihit", {31'd0, ihit}, 32'd1);
        check("unaligned_load", imemload, 32'h8C01_0004);
        @(negedge CLK);
        exp_hit++;
        imemREN = 1'b0;

        // flush drops a valid line; flush with a pending miss starts no fill
        fill(32'h0000_0004, 1, 32'hAAAA_0004);
        flush    = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        #1;
        check("flush_ihit", {31'd0, ihit}, 32'd0);
        @(negedge CLK);
        flush   = 1'b0;
        imemREN = 1'b0;
        #1;
        check("flush_no_fetch", {31'd0, iREN}, 32'd0);
        check_counts("flush");
        fill(32'h0000_0004, 0, 32'hAAAA_0004);

        // flush on the fill-completion cycle leaves the frame invalid
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0008;
        iwait    = 1'b1;
        @(negedge CLK);
        exp_miss++;
        iwait = 1'b0;
        iload = 32'h0808_0808;
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        iwait = 1'b1;
        #1;
        check("flushfill_iren", {31'd0, iREN}, 32'd0);
        check("flushfill_ihit", {31'd0, ihit}, 32'd0);
        @(negedge CLK);
        exp_miss++;
        check("flushfill_refetch", {31'd0, iREN}, 32'd1);
        iwait = 1'b0;
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        check("flushfill_hit", {31'd0, ihit}, 32'd1);
        check("flushfill_load", imemload, 32'h0808_0808);
        @(negedge CLK);
        exp_hit++;
        imemREN = 1'b0;
        check_counts("flushfill");

        // address change and request drop during FETCH do not abort the fill
        imemREN  = 1'b1;
        imemaddr = 32'h0000_000C;
        @(negedge CLK);
        exp_miss++;
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0100;
        #1;
        check("abort_iaddr", iaddr, 32'h0000_000C);
        @(negedge CLK);
        iwait = 1'b0;
        iload = 32'h0C0C_0C0C;
        @(negedge CLK);
        iwait    = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_000C;
        #1;
        check("abort_hit", imemload, 32'h0C0C_0C0C);
        @(negedge CLK);
        exp_hit++;
        imemREN = 1'b0;
        check_counts("abort");

        // reset during FETCH abandons the fill
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0010;
        iwait    = 1'b1;
        @(negedge CLK);
        RST   = 1'b1;
        iload = 32'h1010_1010;
        @(negedge CLK);
        RST      = 1'b0;
        exp_hit  = 32'd0;
        exp_miss = 32'd0;
        #1;
        check("rstf_iren",  {31'd0, iREN}, 32'd0);
        check("rstf_iaddr", iaddr, 32'd0);
        check("rstf_ihit",  {31'd0, ihit}, 32'd0);
        check_counts("rstf");
        @(negedge CLK);
        exp_miss++;
        check("rstf_refetch", {31'd0, iREN}, 32'd1);
        iwait = 1'b0;
        iload = 32'h1010_1010;
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        check("rstf_hit", imemload, 32'h1010_1010);
        @(negedge CLK);
        exp_hit++;
        imemREN = 1'b0;
        check_counts("rstf_after");

        // hit counter wraps
        force dut.hit_count = 32'hFFFF_FFFF;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0010;
        #1;
        release dut.hit_count;
        check("wrap_ihit", {31'd0, ihit}, 32'd1);
        @(negedge CLK);
        imemREN = 1'b0;
        check("wrap_count", hit_count, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_icache

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The module SHALL have no parameters; geometry constants SHALL come from cpu_types_pkg (IIDX_W, default 4, index bits; ITAG_W, default 26, tag bits).
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  datapath instruction address (PC).
REQ-006 ihit  output  1  imemload valid this cycle; datapath may advance PC.
REQ-007 imemload  output  32  instruction word returned to datapath.
REQ-008 flush  input  1  invalidate all frames.
REQ-009 iREN  output  1  read request to memory controller.
REQ-010 iaddr  output  32  word-aligned memory read address.
REQ-011 iwait  input  1  memory busy; iload invalid while high.
REQ-012 iload  input  32  memory read data, valid when iREN high and iwait low.
REQ-013 hit_count  output  32  number of hits since reset.
REQ-014 miss_count  output  32  number of misses since reset.

Function
REQ-015 Cache SHALL be direct-mapped, 16 frames of one 32-bit word each, with valid bit, 26-bit tag and data per frame.
REQ-016 Address decode SHALL be tag = addr[31:6], index = addr[5:2]; addr[1:0] SHALL be ignored.
REQ-017 In IDLE, ihit SHALL equal imemREN AND valid[index] AND tag match, combinationally, same cycle (zero-cycle hit latency).
REQ-018 imemload SHALL be data[index] when ihit=1, else 32'h0.
REQ-019 FSM SHALL have exactly two states: IDLE and FETCH.
REQ-020 IDLE->FETCH SHALL occur when imemREN=1, no hit and flush=0; the miss address SHALL be latched into a 32-bit miss register with bits [1:0] forced to 0.
REQ-021 In FETCH, iREN SHALL be 1 and iaddr SHALL equal the latched miss address; in IDLE, iREN SHALL be 0 and iaddr SHALL hold the last latched value.
REQ-022 In FETCH with iwait=1, the FSM SHALL remain in FETCH with no state change.
REQ-023 In FETCH with iwait=0, iload SHALL be written to the frame of the latched index, tag written, valid set, and FSM return to IDLE; the access SHALL hit on the following cycle (miss latency = memory latency + 1 cycle).
REQ-024 ihit SHALL be 0 in every FETCH cycle.
REQ-025 imemaddr changes or imemREN deassertion during FETCH SHALL NOT abort the fill; the latched address is completed.
REQ-026 flush=1 SHALL clear all valid bits at the next edge in any state; an IDLE->FETCH transition SHALL NOT start that cycle.
REQ-027 flush=1 in the same cycle as fill completion SHALL leave the filled frame invalid (flush wins), FSM still returning to IDLE.
REQ-028 hit_count SHALL increment by 1 on each IDLE cycle with ihit=1; miss_count SHALL increment by 1 on each IDLE->FETCH transition; both SHALL wrap modulo 2^32.
REQ-029 Two misses to different tags with the same index SHALL evict: the second fill overwrites the frame.

Reset
REQ-030 RST=1 at a rising edge SHALL clear all valid bits, force IDLE, clear hit_count, miss_count and the miss register; tag and data arrays need not be reset.
REQ-031 Following reset, outputs SHALL be ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0.
REQ-032 RST asserted mid-FETCH SHALL abandon the fill, write nothing, and return to IDLE with iREN=0 the following cycle.
REQ-033 RST SHALL take priority over flush and all FSM transitions.

Structure
REQ-034 cpu_types_pkg SHALL hold IIDX_W, ITAG_W, the icachef_t packed struct (tag[25:0], idx[3:0], bytoff[1:0]) and the icache state enum (IDLE, FETCH).
REQ-035 icache SHALL be a single module with no sub-modules; the frame array, FSM and counters are inline.

Verification
REQ-036 Post-reset read of 0x00000000, iwait high 3 cycles then iload=0x8C010004 -> iREN high 4 cycles, iaddr=0x00000000, ihit=1 with imemload=0x8C010004 on the cycle after iwait falls, miss_count=1, hit_count=1.
REQ-037 Read 0x00000040 after 0x00000000 filled (same index 0, different tag) -> miss, frame 0 replaced; re-read 0x00000000 -> second miss, miss_count=3.
REQ-038 Fill 0x00000004, assert flush one cycle, read 0x00000004 -> miss with iREN=1, iaddr=0x00000004.
REQ-039 flush asserted on the fill-completion cycle for 0x00000008 -> next read of 0x00000008 misses again.
REQ-040 RST asserted during FETCH with iwait=1 -> next cycle iREN=0, counters 0, re-read misses.
REQ-041 Preload hit_count to 0xFFFFFFFF via 2^32-1 hits (or forced) then one hit -> hit_count=0x00000000.
